// File: rtl/adder_sched.sv
// adder_sched: round-robin scheduler that runs add jobs from two requesters on an AXI4-Lite adder slave.
// Optional feature: define ADDER_SCHED_TIMEOUT_EN to abort any AXI phase stalled for 256 cycles.
module adder_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    m0_axi_aclk,
    input  logic                    m0_axi_areset,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [DATA_WIDTH-1:0]   req0_opa,
    input  logic [DATA_WIDTH-1:0]   req0_opb,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [DATA_WIDTH-1:0]   req1_opa,
    input  logic [DATA_WIDTH-1:0]   req1_opb,
    output logic                    rsp0_valid,
    output logic                    rsp1_valid,
    output logic [DATA_WIDTH-1:0]   rsp_result,
    output logic                    rsp_err,
    output logic [ADDR_WIDTH-1:0]   m0_axi_awaddr,
    output logic                    m0_axi_awvalid,
    input  logic                    m0_axi_awready,
    output logic [DATA_WIDTH-1:0]   m0_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m0_axi_wstrb,
    output logic                    m0_axi_wvalid,
    input  logic                    m0_axi_wready,
    input  logic [1:0]              m0_axi_bresp,
    input  logic                    m0_axi_bvalid,
    output logic                    m0_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m0_axi_araddr,
    output logic                    m0_axi_arvalid,
    input  logic                    m0_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m0_axi_rdata,
    input  logic [1:0]              m0_axi_rresp,
    input  logic                    m0_axi_rvalid,
    output logic                    m0_axi_rready,
    output logic [2:0]              state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // The requester side is a pulse: reqN_ready is high for exactly one cycle after its job
    // was latched, and rspN_valid is high for exactly one cycle with rsp_result/rsp_err.

    localparam logic [ADDR_WIDTH-1:0] ADDR_OPA = ADDR_WIDTH'(8'h00);
    localparam logic [ADDR_WIDTH-1:0] ADDR_OPB = ADDR_WIDTH'(8'h04);
    localparam logic [ADDR_WIDTH-1:0] ADDR_RES = ADDR_WIDTH'(8'h08);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR_A = 3'd1,
        WR_B = 3'd2,
        RD   = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t                state;
    logic                  last_grant;
    logic                  gnt;
    logic                  launched;
    logic [DATA_WIDTH-1:0] opa_q;
    logic [DATA_WIDTH-1:0] opb_q;

    logic                  any_valid;
    logic                  grant_sel;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  b_hs;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  in_phase;
    logic                  phase_done;
    logic                  phase_timeout;
    logic                  job_done;
    logic                  job_fail;
    logic                  job_end;

    assign state_dbg     = state;
    assign m0_axi_wstrb  = '1;
    assign m0_axi_araddr = ADDR_RES;
    assign m0_axi_bready = ((state == WR_A) && launched) || (state == WR_B);
    assign m0_axi_rready = (state == RD);

    assign aw_hs      = m0_axi_awvalid & m0_axi_awready;
    assign w_hs       = m0_axi_wvalid & m0_axi_wready;
    assign b_hs       = m0_axi_bvalid & m0_axi_bready;
    assign ar_hs      = m0_axi_arvalid & m0_axi_arready;
    assign r_hs       = m0_axi_rvalid & m0_axi_rready;
    assign in_phase   = (state == WR_A) || (state == WR_B) || (state == RD);
    assign phase_done = b_hs | r_hs;
    assign job_end    = job_done | job_fail;

    // last_grant == 1 means requester 1 was served last, so requester 0 wins a tie.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_sel = ~last_grant;
        end else begin
            grant_sel = req1_valid;
        end
    end

    always_comb begin
        job_done = 1'b0;
        job_fail = 1'b0;
        case (state)
            WR_A, WR_B: begin
                if (b_hs) begin
                    job_fail = (m0_axi_bresp != 2'b00);
                end else begin
                    job_fail = phase_timeout;
                end
            end
            RD: begin
                if (r_hs) begin
                    job_done = 1'b1;
                    job_fail = (m0_axi_rresp != 2'b00);
                end else begin
                    job_fail = phase_timeout;
                end
            end
            default: begin
                job_done = 1'b0;
                job_fail = 1'b0;
            end
        endcase
    end

`ifdef ADDER_SCHED_TIMEOUT_EN
    logic [7:0] phase_cnt;

    // Counts cycles spent in the current AXI phase; the 256th stalled cycle aborts the job.
    assign phase_timeout = (phase_cnt == 8'hFF);

    always_ff @(posedge m0_axi_aclk or posedge m0_axi_areset) begin
        if (m0_axi_areset) begin
            phase_cnt <= 8'd0;
        end else if (in_phase && !phase_done) begin
            phase_cnt <= phase_cnt + 8'd1;
        end else begin
            phase_cnt <= 8'd0;
        end
    end
`else
    assign phase_timeout = 1'b0;
`endif

    always_ff @(posedge m0_axi_aclk or posedge m0_axi_areset) begin
        if (m0_axi_areset) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            gnt            <= 1'b0;
            launched       <= 1'b0;
            opa_q          <= '0;
            opb_q          <= '0;
            req0_ready     <= 1'b0;
            req1_ready     <= 1'b0;
            rsp0_valid     <= 1'b0;
            rsp1_valid     <= 1'b0;
            rsp_result     <= '0;
            rsp_err        <= 1'b0;
            m0_axi_awaddr  <= '0;
            m0_axi_awvalid <= 1'b0;
            m0_axi_wdata   <= '0;
            m0_axi_wvalid  <= 1'b0;
            m0_axi_arvalid <= 1'b0;
        end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            if (aw_hs) m0_axi_awvalid <= 1'b0;
            if (w_hs)  m0_axi_wvalid  <= 1'b0;
            if (ar_hs) m0_axi_arvalid <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_valid) begin
                        gnt        <= grant_sel;
                        last_grant <= grant_sel;
                        opa_q      <= grant_sel ? req1_opa : req0_opa;
                        opb_q      <= grant_sel ? req1_opb : req0_opb;
                        req0_ready <= ~grant_sel;
                        req1_ready <= grant_sel;
                        launched   <= 1'b0;
                        state      <= WR_A;
                    end
                end
                WR_A: begin
                    // First WR_A cycle only arms the write; the bus sees it on the next cycle.
                    if (!launched) begin
                        launched       <= 1'b1;
                        m0_axi_awaddr  <= ADDR_OPA;
                        m0_axi_wdata   <= opa_q;
                        m0_axi_awvalid <= 1'b1;
                        m0_axi_wvalid  <= 1'b1;
                    end else if (b_hs && !job_fail) begin
                        m0_axi_awaddr  <= ADDR_OPB;
                        m0_axi_wdata   <= opb_q;
                        m0_axi_awvalid <= 1'b1;
                        m0_axi_wvalid  <= 1'b1;
                        state          <= WR_B;
                    end
                end
                WR_B: begin
                    if (b_hs && !job_fail) begin
                        m0_axi_arvalid <= 1'b1;
                        state          <= RD;
                    end
                end
                RD: begin
                    state <= RD;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Completion, slave error or timeout: abandon remaining phases and answer.
            if (job_end) begin
                m0_axi_awvalid <= 1'b0;
                m0_axi_wvalid  <= 1'b0;
                m0_axi_arvalid <= 1'b0;
                rsp0_valid     <= ~gnt;
                rsp1_valid     <= gnt;
                rsp_err        <= job_fail;
                rsp_result     <= job_fail ? '0 : m0_axi_rdata;
                state          <= RESP;
            end
        end
    end

endmodule

// File: tb/tb_adder_sched.sv
// tb_adder_sched: directed checks of adder_sched against a behavioural AXI4-Lite adder slave.
// Expected responses go into a queue at acceptance; a monitor pops them on each rspN_valid.
module tb_adder_sched;

    localparam int DW   = 32;
    localparam int AW   = 8;
    localparam int SB_W = DW + 3;

    logic          clk;
    logic          rst;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DW-1:0] req0_opa, req0_opb, req1_opa, req1_opb;
    logic          rsp0_valid, rsp1_valid, rsp_err;
    logic [DW-1:0] rsp_result;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic [1:0]    bresp, rresp;
    logic [2:0]    state_dbg;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ready_cyc = 0;
    int rsp_seen = 0;
    int w_extra = 0;
    int aw_drop = 0;

    logic [SB_W-1:0] exp_q[$];
    int              grant_log[$];
    logic [AW-1:0]   wr_addr_log[$];
    logic [DW-1:0]   wr_data_log[$];
    logic [AW-1:0]   rd_addr_log[$];

    int         cfg_aw_delay = -1;
    logic       cfg_ar_en = 1'b1;
    logic [1:0] cfg_bresp_b = 2'b00;

    int          t_id[3] = '{1, 0, 1};
    logic [31:0] t_a[3]  = '{32'hFFFF_FFFF, 32'h0000_1234, 32'h8000_0000};
    logic [31:0] t_b[3]  = '{32'h0000_0001, 32'h0000_1111, 32'h8000_0001};
    logic [31:0] t_r[3]  = '{32'h0000_0000, 32'h0000_2345, 32'h0000_0001};

    adder_sched #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .m0_axi_aclk    (clk),
        .m0_axi_areset  (rst),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_opa       (req0_opa),
        .req0_opb       (req0_opb),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_opa       (req1_opa),
        .req1_opb       (req1_opb),
        .rsp0_valid     (rsp0_valid),
        .rsp1_valid     (rsp1_valid),
        .rsp_result     (rsp_result),
        .rsp_err        (rsp_err),
        .m0_axi_awaddr  (awaddr),
        .m0_axi_awvalid (awvalid),
        .m0_axi_awready (awready),
        .m0_axi_wdata   (wdata),
        .m0_axi_wstrb   (wstrb),
        .m0_axi_wvalid  (wvalid),
        .m0_axi_wready  (wready),
        .m0_axi_bresp   (bresp),
        .m0_axi_bvalid  (bvalid),
        .m0_axi_bready  (bready),
        .m0_axi_araddr  (araddr),
        .m0_axi_arvalid (arvalid),
        .m0_axi_arready (arready),
        .m0_axi_rdata   (rdata),
        .m0_axi_rresp   (rresp),
        .m0_axi_rvalid  (rvalid),
        .m0_axi_rready  (rready),
        .state_dbg      (state_dbg)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Slave: sample handshakes at negedge, update its outputs just after the next posedge.
    initial begin : axi_slave
        logic          aw_h, w_h, ar_h, b_h, r_h;
        logic          s_aw_done, s_w_done, aw_seen;
        logic [AW-1:0] s_awaddr, s_araddr;
        logic [DW-1:0] s_wdata, reg_a, reg_b;
        int            w_age;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b1; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        s_aw_done = 1'b0; s_w_done = 1'b0; aw_seen = 1'b0; w_age = 0;
        s_awaddr = '0; s_araddr = '0; s_wdata = '0; reg_a = '0; reg_b = '0;
        forever begin
            @(negedge clk);
            aw_h = awvalid && awready;
            w_h  = wvalid && wready;
            ar_h = arvalid && arready;
            b_h  = bvalid && bready;
            r_h  = rvalid && rready;
            if (rst) begin
                s_aw_done = 1'b0; s_w_done = 1'b0; aw_seen = 1'b0; w_age = 0;
            end else begin
                if (w_h && s_w_done) w_extra++;
                if (aw_seen && !awvalid) aw_drop++;
                aw_seen = awvalid && !aw_h;
                if (aw_h) begin s_aw_done = 1'b1; s_awaddr = awaddr; end
                if (w_h) begin s_w_done = 1'b1; s_wdata = wdata; end
                if (ar_h) s_araddr = araddr;
            end
            @(posedge clk);
            #1;
            if (rst) begin
                bvalid = 1'b0; rvalid = 1'b0;
                awready = (cfg_aw_delay < 0);
                arready = cfg_ar_en;
            end else begin
                if (b_h) bvalid = 1'b0;
                if (r_h) rvalid = 1'b0;
                if (s_aw_done && s_w_done) begin
                    wr_addr_log.push_back(s_awaddr);
                    wr_data_log.push_back(s_wdata);
                    if (s_awaddr == 8'h00) reg_a = s_wdata;
                    if (s_awaddr == 8'h04) reg_b = s_wdata;
                    bvalid = 1'b1;
                    bresp = (s_awaddr == 8'h04) ? cfg_bresp_b : 2'b00;
                    s_aw_done = 1'b0; s_w_done = 1'b0; w_age = 0;
                end else if (s_w_done) begin
                    w_age++;
                end
                if (ar_h) begin
                    rd_addr_log.push_back(s_araddr);
                    rvalid = 1'b1;
                    rdata = reg_a + reg_b;
                    rresp = 2'b00;
                end
                arready = cfg_ar_en;
                awready = (cfg_aw_delay < 0) ? 1'b1 : (s_w_done && !s_aw_done && (w_age >= cfg_aw_delay));
            end
        end
    end

    // Scoreboard monitor
    initial begin : monitor
        logic [SB_W-1:0] got, exp;
        forever begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) begin
                rsp_seen++;
                got = {rsp1_valid, rsp0_valid, rsp_err, rsp_result};
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp: got 0x%0h expected no response", got);
                end else begin
                    exp = exp_q.pop_front();
                    check("scoreboard", 64'(got), 64'(exp));
                end
            end
        end
    end

    task automatic issue(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] res, input logic err, input bit push);
        int   n;
        logic rdy;
        if (id == 0) begin
            req0_opa = a; req0_opb = b; req0_valid = 1'b1;
        end else begin
            req1_opa = a; req1_opb = b; req1_valid = 1'b1;
        end
        n = 0;
        rdy = 1'b0;
        while (!rdy && n < 400) begin
            @(negedge clk);
            n++;
            rdy = (id == 0) ? req0_ready : req1_ready;
        end
        if (rdy) begin
            grant_log.push_back(id);
            ready_cyc = cyc;
            if (push) exp_q.push_back({id == 1, id == 0, err, res});
        end else begin
            fail_now("accept_wait");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic release_req(input int id);
        if (id == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain_wait");
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_arvalid(output bit seen);
        int n;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            seen = arvalid;
        end
        if (!seen) fail_now("arvalid_wait");
    endtask

    initial begin : stim
        bit found;
        bit seen;
        int n;
        int rd_before;
        int rsp_before;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_opa = '0; req0_opb = '0; req1_opa = '0; req1_opb = '0;

        @(negedge clk);
        check("rst_handshakes", {req0_ready, req1_ready, rsp0_valid, rsp1_valid}, 0);
        check("rst_axi_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
        check("rst_result", {rsp_err, rsp_result}, 0);
        check("rst_state", state_dbg, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic job 5 + 7 with latency
        issue(0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b1);
        release_req(0);
        found = 1'b0;
        n = 0;
        while (!found && n < 30) begin
            @(negedge clk);
            n++;
            if (rsp0_valid) begin
                found = 1'b1;
                check("latency_rdy_to_rsp", 64'(cyc - ready_cyc), 7);
            end
        end
        if (!found) fail_now("rsp0_wait");
        drain(50);
        check("wr_count", wr_addr_log.size(), 2);
        check("wr0_addr", wr_addr_log[0], 8'h00);
        check("wr0_data", wr_data_log[0], 32'd5);
        check("wr1_addr", wr_addr_log[1], 8'h04);
        check("wr1_data", wr_data_log[1], 32'd7);
        check("rd_count", rd_addr_log.size(), 1);
        check("rd_addr", rd_addr_log[0], 8'h08);

        // Directed vectors including wrap-around
        for (int i = 0; i < 3; i++) begin
            issue(t_id[i], t_a[i], t_b[i], t_r[i], 1'b0, 1'b1);
            release_req(t_id[i]);
            drain(50);
        end

        // Round robin after reset: req0, req1, req0
        do_reset();
        grant_log.delete();
        fork
            begin
                issue(0, 32'd10, 32'd20, 32'd30, 1'b0, 1'b1);
                issue(0, 32'd3, 32'd4, 32'd7, 1'b0, 1'b1);
                release_req(0);
            end
            begin
                issue(1, 32'd100, 32'd200, 32'd300, 1'b0, 1'b1);
                release_req(1);
            end
        join
        drain(100);
        check("rr_grant_count", grant_log.size(), 3);
        check("rr_grant0", grant_log[0], 0);
        check("rr_grant1", grant_log[1], 1);
        check("rr_grant2", grant_log[2], 0);

        // Write error on opB: no read, error response
        cfg_bresp_b = 2'b10;
        rd_before = rd_addr_log.size();
        issue(1, 32'd9, 32'd9, 32'd0, 1'b1, 1'b1);
        release_req(1);
        drain(50);
        check("bresp_err_no_read", rd_addr_log.size() - rd_before, 0);
        cfg_bresp_b = 2'b00;

        // awready lags wready by 3 cycles
        cfg_aw_delay = 3;
        w_extra = 0;
        aw_drop = 0;
        wr_addr_log.delete();
        wr_data_log.delete();
        issue(0, 32'd1, 32'd2, 32'd3, 1'b0, 1'b1);
        release_req(0);
        drain(60);
        check("wvalid_dropped", w_extra, 0);
        check("awvalid_held", aw_drop, 0);
        check("delay_wr_count", wr_addr_log.size(), 2);
        check("delay_wr0_addr", wr_addr_log[0], 8'h00);
        cfg_aw_delay = -1;

        // Reset while waiting in RD
        cfg_ar_en = 1'b0;
        issue(1, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
        release_req(1);
        wait_arvalid(seen);
        rst = 1'b1;
        #1;
        check("rst_in_rd_arvalid", arvalid, 0);
        check("rst_in_rd_state", state_dbg, 0);
        check("rst_in_rd_result", {rsp_err, rsp_result}, 0);
        cfg_ar_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_before = rsp_seen;
        repeat (12) @(negedge clk);
        check("rst_in_rd_no_rsp", rsp_seen - rsp_before, 0);
        issue(0, 32'd40, 32'd2, 32'd42, 1'b0, 1'b1);
        release_req(0);
        drain(50);

        // arready never asserted
        cfg_ar_en = 1'b0;
`ifdef ADDER_SCHED_TIMEOUT_EN
        issue(0, 32'd1, 32'd1, 32'd0, 1'b1, 1'b1);
`else
        issue(0, 32'd1, 32'd1, 32'd0, 1'b1, 1'b0);
`endif
        release_req(0);
        wait_arvalid(seen);
        n = 0;
        while (arvalid && n < 400) begin
            n++;
            @(negedge clk);
        end
`ifdef ADDER_SCHED_TIMEOUT_EN
        check("timeout_arvalid_cycles", n, 256);
        check("timeout_arvalid_low", arvalid, 0);
        cfg_ar_en = 1'b1;
        drain(20);
`else
        check("no_timeout_arvalid_cycles", n, 400);
        check("no_timeout_arvalid_high", arvalid, 1);
        cfg_ar_en = 1'b1;
        do_reset();
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
